// File: rtl/sentry_evict_serializer_if.sv
// Eviction bus between the DCache eviction sources and the victim-CAM serializer.
`ifndef LINE_WIDTH
`define LINE_WIDTH 32
`endif

interface sentry_evict_serializer_if #(
  parameter int unsigned PTR_WIDTH      = 3,
  parameter int unsigned DROP_CNT_WIDTH = 16
);
  typedef logic [`LINE_WIDTH-1:0] line_t;

  logic                      evict_a_valid;
  line_t                     evict_a_line;
  logic                      evict_b_valid;
  line_t                     evict_b_line;
  logic                      cache_evicted;
  line_t                     cache_evict_line;
  logic [PTR_WIDTH:0]        queue_count;
  logic                      overflow;
  logic [DROP_CNT_WIDTH-1:0] drop_count;

  // DCache side: drives evictions, observes CAM writes and status
  modport master (
    output evict_a_valid, evict_a_line, evict_b_valid, evict_b_line,
    input  cache_evicted, cache_evict_line, queue_count, overflow, drop_count
  );

  // Serializer side
  modport slave (
    input  evict_a_valid, evict_a_line, evict_b_valid, evict_b_line,
    output cache_evicted, cache_evict_line, queue_count, overflow, drop_count
  );
endinterface

// File: rtl/sentry_evict_serializer.sv
// Merges two DCache eviction streams into the victim CAM's single write port,
// preserving arrival order (FIFO, then A, then B) with a small burst FIFO.
`ifndef LINE_WIDTH
`define LINE_WIDTH 32
`endif

module sentry_evict_serializer #(
  parameter int unsigned PTR_WIDTH      = 3,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  sentry_evict_serializer_if.slave    bus
);
  localparam int unsigned DEPTH  = 1 << PTR_WIDTH;
  localparam int unsigned CNT_W  = PTR_WIDTH + 1;
  localparam int unsigned LINE_W = `LINE_WIDTH;

  typedef logic [LINE_W-1:0] line_t;

  line_t                     mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      evicted_q, evicted_d;
  line_t                     line_q, line_d;
  logic                      overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  logic                      pop;
  logic                      c0_v, c1_v;
  line_t                     c0_line, c1_line;
  logic                      acc0, acc1;
  logic [CNT_W-1:0]          free;
  logic [1:0]                n_drop;
  logic [DROP_CNT_WIDTH:0]   drop_sum;

  // Output selection, push-candidate compaction, capacity and drop accounting
  always_comb begin
    pop       = (count_q != '0);
    c0_v      = 1'b0;
    c1_v      = 1'b0;
    c0_line   = bus.evict_a_line;
    c1_line   = bus.evict_b_line;
    evicted_d = 1'b0;
    line_d    = line_q;

    if (pop) begin
      evicted_d = 1'b1;
      line_d    = mem_q[rd_ptr_q];
      if (bus.evict_a_valid) begin
        c0_v    = 1'b1;
        c0_line = bus.evict_a_line;
        c1_v    = bus.evict_b_valid;
        c1_line = bus.evict_b_line;
      end else begin
        c0_v    = bus.evict_b_valid;
        c0_line = bus.evict_b_line;
      end
    end else if (bus.evict_a_valid) begin
      evicted_d = 1'b1;
      line_d    = bus.evict_a_line;
      c0_v      = bus.evict_b_valid;
      c0_line   = bus.evict_b_line;
    end else if (bus.evict_b_valid) begin
      evicted_d = 1'b1;
      line_d    = bus.evict_b_line;
    end

    // Candidates are compacted, so c1 only exists alongside c0 and needs two slots
    free   = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
    acc0   = c0_v && (free >= CNT_W'(1));
    acc1   = c1_v && (free >= CNT_W'(2));
    n_drop = 2'(c0_v && !acc0) + 2'(c1_v && !acc1);

    rd_ptr_d = rd_ptr_q + PTR_WIDTH'(pop);
    wr_ptr_d = wr_ptr_q + PTR_WIDTH'(acc0) + PTR_WIDTH'(acc1);
    count_d  = count_q - CNT_W'(pop) + CNT_W'(acc0) + CNT_W'(acc1);

    drop_sum   = {1'b0, drop_q} + (DROP_CNT_WIDTH + 1)'(n_drop);
    drop_d     = drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
    overflow_d = overflow_q | (n_drop != 2'd0);
  end

  // FIFO storage; unreset, writes suppressed while rst is asserted
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (acc0) mem_q[wr_ptr_q] <= c0_line;
      if (acc1) mem_q[wr_ptr_q + PTR_WIDTH'(1)] <= c1_line;
    end
  end

  // Control, pointer and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      evicted_q  <= 1'b0;
      line_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      evicted_q  <= evicted_d;
      line_q     <= line_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.cache_evicted    = evicted_q;
  assign bus.cache_evict_line = line_q;
  assign bus.queue_count      = count_q;
  assign bus.overflow         = overflow_q;
  assign bus.drop_count       = drop_q;

endmodule

// File: tb/tb_sentry_evict_serializer.sv
// Scoreboarded bench for sentry_evict_serializer: stimulus queues the
// expected CAM writes with their cycle, a negedge monitor consumes them.
`ifndef LINE_WIDTH
`define LINE_WIDTH 32
`endif

module tb_sentry_evict_serializer;
  typedef struct {
    logic [31:0] line;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   base;
  int   exp_drop;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sentry_evict_serializer_if #(.PTR_WIDTH(3), .DROP_CNT_WIDTH(16)) bus ();
  sentry_evict_serializer_if #(.PTR_WIDTH(3), .DROP_CNT_WIDTH(2))  bus2 ();

  sentry_evict_serializer #(.PTR_WIDTH(3), .DROP_CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sentry_evict_serializer #(.PTR_WIDTH(3), .DROP_CNT_WIDTH(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [31:0] al,
                       input logic bv, input logic [31:0] bl);
    bus.evict_a_valid = av;
    bus.evict_a_line  = al;
    bus.evict_b_valid = bv;
    bus.evict_b_line  = bl;
  endtask

  task automatic drive2(input logic av, input logic [31:0] al,
                        input logic bv, input logic [31:0] bl);
    bus2.evict_a_valid = av;
    bus2.evict_a_line  = al;
    bus2.evict_b_valid = bv;
    bus2.evict_b_line  = bl;
  endtask

  task automatic expect_out(input logic [31:0] line, input int c);
    exp_t e;
    e.line = line;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every CAM write must match the oldest expected line and cycle
  always @(negedge clk) begin
    if (bus.cache_evicted) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL emit: got line %h at cycle %0d, expected no write", bus.cache_evict_line, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (bus.cache_evict_line !== mon_e.line || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL emit: got line %h at cycle %0d, expected %h at cycle %0d",
                   bus.cache_evict_line, cyc, mon_e.line, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    drive(1'b0, '0, 1'b0, '0);
    drive2(1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_evicted",  32'(bus.cache_evicted),    32'd0);
    chk("rst_line",     bus.cache_evict_line,       32'd0);
    chk("rst_count",    32'(bus.queue_count),      32'd0);
    chk("rst_overflow", 32'(bus.overflow),         32'd0);
    chk("rst_drops",    32'(bus.drop_count),       32'd0);

    // Lone A with empty FIFO: one-cycle latency, line held afterwards
    step();
    drive(1'b1, 32'hAAAA_AAAA, 1'b0, '0);
    expect_out(32'hAAAA_AAAA, cyc + 1);
    step();
    drive(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    chk("lone_count", 32'(bus.queue_count), 32'd0);
    step();
    @(negedge clk);
    chk("lone_idle_evicted", 32'(bus.cache_evicted), 32'd0);
    chk("lone_idle_line",    bus.cache_evict_line,    32'hAAAA_AAAA);
    chk("lone_idle_count",   32'(bus.queue_count),   32'd0);

    // A and B together: A bypasses, B queued one entry
    step();
    drive(1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222);
    expect_out(32'h1111_1111, cyc + 1);
    expect_out(32'h2222_2222, cyc + 2);
    step();
    drive(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    chk("pair_count1", 32'(bus.queue_count), 32'd1);
    step();
    @(negedge clk);
    chk("pair_count0", 32'(bus.queue_count), 32'd0);
    step();
    @(negedge clk);
    chk("pair_idle_evicted", 32'(bus.cache_evicted), 32'd0);

    // Both sources every cycle 0..8: FIFO fills, B8 dropped
    for (int k = 0; k <= 8; k++) begin
      step();
      if (k == 0) begin
        base = cyc;
        for (int i = 0; i < 8; i++) begin
          expect_out(32'hA000_0000 | 32'(i), base + 1 + 2 * i);
          expect_out(32'hB000_0000 | 32'(i), base + 2 + 2 * i);
        end
        expect_out(32'hA000_0008, base + 17);
      end
      drive(1'b1, 32'hA000_0000 | 32'(k), 1'b1, 32'hB000_0000 | 32'(k));
      @(negedge clk);
      if (k > 0) chk("burst_count", 32'(bus.queue_count), 32'(k));
    end
    step();
    drive(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    chk("burst_full_count", 32'(bus.queue_count), 32'd8);
    chk("burst_overflow",   32'(bus.overflow),    32'd1);
    chk("burst_drops",      32'(bus.drop_count),  32'd1);
    repeat (18) step();
    @(negedge clk);
    chk("burst_drained_count", 32'(bus.queue_count), 32'd0);
    chk("burst_drained_sb",    32'(sb.size()),       32'd0);

    // Reset with five entries queued: stale lines must never appear
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) begin
        base = cyc;
        expect_out(32'hC000_0000, base + 1);
        expect_out(32'hD000_0000, base + 2);
        expect_out(32'hC000_0001, base + 3);
        expect_out(32'hD000_0001, base + 4);
        expect_out(32'hC000_0002, base + 5);
      end
      drive(1'b1, 32'hC000_0000 | 32'(k), 1'b1, 32'hD000_0000 | 32'(k));
    end
    step();
    rst = 1'b1;
    drive(1'b1, 32'hBAD0_0001, 1'b0, '0);
    @(negedge clk);
    chk("pre_rst_count",    32'(bus.queue_count), 32'd5);
    chk("pre_rst_overflow", 32'(bus.overflow),    32'd1);
    step();
    rst = 1'b0;
    drive(1'b1, 32'hE000_0001, 1'b0, '0);
    expect_out(32'hE000_0001, cyc + 1);
    @(negedge clk);
    chk("mid_rst_evicted",  32'(bus.cache_evicted), 32'd0);
    chk("mid_rst_line",     bus.cache_evict_line,    32'd0);
    chk("mid_rst_count",    32'(bus.queue_count),   32'd0);
    chk("mid_rst_overflow", 32'(bus.overflow),      32'd0);
    chk("mid_rst_drops",    32'(bus.drop_count),    32'd0);
    step();
    drive(1'b0, '0, 1'b0, '0);
    repeat (12) step();
    @(negedge clk);
    chk("post_rst_count", 32'(bus.queue_count), 32'd0);
    chk("post_rst_sb",    32'(sb.size()),       32'd0);

    // B-only stream: every line bypasses, FIFO never used
    for (int k = 0; k < 20; k++) begin
      step();
      drive(1'b0, '0, 1'b1, 32'h5000_0000 + 32'(k));
      expect_out(32'h5000_0000 + 32'(k), cyc + 1);
      @(negedge clk);
      chk("bstream_count", 32'(bus.queue_count), 32'd0);
    end
    step();
    drive(1'b0, '0, 1'b0, '0);
    repeat (3) step();
    @(negedge clk);
    chk("bstream_overflow", 32'(bus.overflow), 32'd0);
    chk("bstream_sb",       32'(sb.size()),    32'd0);

    // 2-bit drop counter on the second instance: saturates at 3
    for (int k = 0; k < 14; k++) begin
      step();
      drive2(1'b1, 32'h7000_0000 | 32'(k), 1'b1, 32'h8000_0000 | 32'(k));
      @(negedge clk);
      if (k > 0) begin
        exp_drop = (k - 1 < 8) ? 0 : ((k - 8 > 3) ? 3 : k - 8);
        chk("sat_drops", 32'(bus2.drop_count), 32'(exp_drop));
      end
    end
    step();
    drive2(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    chk("sat_final_drops",    32'(bus2.drop_count), 32'd3);
    chk("sat_final_overflow", 32'(bus2.overflow),   32'd1);
    chk("sat_final_count",    32'(bus2.queue_count), 32'd8);

    repeat (2) step();
    @(negedge clk);
    chk("final_sb", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sentry_evict_serializer.md
Name: sentry_evict_serializer

Overview:
- Upstream feeder of the sentry DCache sequential victim CAM.
- Collects evicted lines from two independent DCache eviction sources:
  - A: replacement/writeback eviction.
  - B: invalidation/flush eviction.
- Serializes them in strict arrival order into the CAM's single eviction port, at most one line per cycle, one cycle after the event.
- Absorbs bursts in a small FIFO. Reports occupancy, a sticky overflow flag and a drop count.

Parameters:
PTR_WIDTH, 3, FIFO pointer width; DEPTH = 2**PTR_WIDTH entries (default 8).
DROP_CNT_WIDTH, 16, width of saturating dropped-event counter.

Ports:
clk  input  1  sentry clock
rst  input  1  synchronous active-high reset
evict_a_valid  input  1  source A evicts a line this cycle
evict_a_line  input  `LINE_WIDTH (line_t)  source A evicted line
evict_b_valid  input  1  source B evicts a line this cycle
evict_b_line  input  `LINE_WIDTH (line_t)  source B evicted line
cache_evicted  output  1  registered; one line presented to victim CAM this cycle
cache_evict_line  output  `LINE_WIDTH (line_t)  registered line for CAM write
queue_count  output  PTR_WIDTH+1  entries currently held in FIFO (excludes output register)
overflow  output  1  sticky; set when any event was dropped
drop_count  output  DROP_CNT_WIDTH  saturating count of dropped events

Behaviour:
- One clock (clk); rst is synchronous, active-high. All outputs are registered.
- Reset values: cache_evicted=0, cache_evict_line=0, queue_count=0, overflow=0, drop_count=0. FIFO read/write pointers = 0.
- Events presented during a reset cycle are discarded and not counted as drops.
- Ordering:
  - Global arrival order is preserved.
  - Within one cycle, A is older than B.
  - FIFO contents are older than any same-cycle arrival.
- Per-cycle selection (Q = queue_count at start of cycle):
  - Q>0: pop FIFO head into the output register (cache_evicted=1 next cycle). All valid arrivals become push candidates (A then B).
  - Q=0 and A valid: A bypasses into the output register. B, if valid, is a push candidate.
  - Q=0, A invalid, B valid: B bypasses into the output register.
  - Q=0, no arrivals: cache_evicted=0 next cycle. cache_evict_line holds its previous value.
- Latency: a lone event in cycle N with an empty FIFO drives cache_evicted=1 in cycle N+1, exactly one cycle.
- Capacity rule:
  - free = DEPTH - Q + pop, where pop = 1 if Q>0.
  - Push candidates are accepted in order (A, then B) while free > 0.
  - Remaining candidates are dropped. When both cannot fit, B is dropped first.
- Each drop sets overflow (held until rst) and increments drop_count by 1. Two drops in one cycle add 2. drop_count saturates at all-ones.
- queue_count(next) = Q - pop + accepted. It never exceeds DEPTH.
- Pointers wrap modulo DEPTH. Full vs empty is distinguished by queue_count, not by pointer equality.
- No backpressure: the downstream CAM always accepts. No handshake is required on the output.
- FIFO storage needs no reset. The output line is reset to 0.

Test Plan:
- Single A in cycle 5 with line 0xAA..A (empty queue) -> cycle 6: cache_evicted=1, cache_evict_line=0xAA..A. Cycle 7: cache_evicted=0. queue_count stays 0 throughout.
- A=L1 and B=L2 together in cycle 3 -> cycle 4 outputs L1 with queue_count=1. Cycle 5 outputs L2 with queue_count=0. Cycle 6: cache_evicted=0.
- Both sources valid every cycle 0..8 (A=Ak, B=Bk):
  - End of cycle k (k≤7): queue_count=k+1.
  - Cycle 8: A8 accepted, B8 dropped; overflow=1, drop_count=1, queue_count=8.
  - Then idle: output sequence A0,B0,A1,B1,...,A7,B7,A8 on consecutive cycles, then cache_evicted=0.
- Only B valid for 20 consecutive cycles with distinct lines -> each line emitted exactly once, one cycle later, in order. queue_count stays 0. No overflow.
- Drop counter saturation, with DROP_CNT_WIDTH=2: hold the FIFO full and keep forcing drops -> drop_count reaches 3 and stays 3. overflow=1.
- Reset mid-operation: queue_count=5 with overflow=1, assert rst for 1 cycle -> next cycle all outputs 0. Then a fresh A event emits one cycle later with no stale FIFO entries ever appearing.
